// File: rtl/sprite_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_engine_pkg
// Description : Shared constants for the sprite engine. Holds the pivot field
//               width, the default parameter values and a width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_engine_pkg;

  // Width of one packed per-object coordinate field.
  localparam int C_PIVOT_W = 10;

  // Default parameter values.
  localparam int C_DEF_NUM_OBJ     = 4;
  localparam int C_DEF_OBJ_W       = 21;
  localparam int C_DEF_OBJ_H       = 26;
  localparam int C_DEF_MEM_W       = 320;
  localparam int C_DEF_ADDR_W      = 17;
  localparam int C_DEF_SCALE_SHIFT = 1;
  localparam int C_DEF_NUM_FRAMES  = 4;
  localparam int C_DEF_FRAME_DIV   = 8;

  // Bits needed to index n items, never less than one bit.
  function automatic int f_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_engine_if
// Description : Pixel/sprite bus between a video front end and the sprite
//               engine. Suffixes are named from the engine's point of view.
// Ports       : vga_h_i/vga_v_i     current VGA pixel
//               frame_start_i       vblank pulse (shadow load, anim step)
//               pivot_*_i, mem_base_*_i, obj_visible_i  packed object table
//               anim_en_i           animation advance enable
//               addr_o, en_o, obj_id_o  sprite-memory request
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_engine_if
  import sprite_engine_pkg::*;
#(
  parameter int NUM_OBJ = C_DEF_NUM_OBJ,
  parameter int ADDR_W  = C_DEF_ADDR_W
);
  localparam int ID_W = f_idx_w(NUM_OBJ);

  logic [C_PIVOT_W-1:0]         vga_h_i;
  logic [C_PIVOT_W-1:0]         vga_v_i;
  logic                         frame_start_i;
  logic [C_PIVOT_W*NUM_OBJ-1:0] pivot_h_i;
  logic [C_PIVOT_W*NUM_OBJ-1:0] pivot_v_i;
  logic [C_PIVOT_W*NUM_OBJ-1:0] mem_base_h_i;
  logic [C_PIVOT_W*NUM_OBJ-1:0] mem_base_v_i;
  logic [NUM_OBJ-1:0]           obj_visible_i;
  logic                         anim_en_i;
  logic [ADDR_W-1:0]            addr_o;
  logic                         en_o;
  logic [ID_W-1:0]              obj_id_o;

  modport master (
    output vga_h_i, vga_v_i, frame_start_i, pivot_h_i, pivot_v_i,
           mem_base_h_i, mem_base_v_i, obj_visible_i, anim_en_i,
    input  addr_o, en_o, obj_id_o
  );

  modport slave (
    input  vga_h_i, vga_v_i, frame_start_i, pivot_h_i, pivot_v_i,
           mem_base_h_i, mem_base_v_i, obj_visible_i, anim_en_i,
    output addr_o, en_o, obj_id_o
  );

endinterface
`default_nettype wire

// File: rtl/sprite_engine_hit.sv
`default_nettype none
// ============================================================================
// Module      : sprite_hit
// Description : Combinational hit test for one object. Reports whether the
//               logical pixel lies inside the object's box and returns the
//               sheet column (base_h + dx) and row (base_v + dy) of that pixel.
// Ports       : h_i, v_i            logical pixel coordinates
//               pivot_h_i/pivot_v_i object top-left corner (shadow copy)
//               base_h_i/base_v_i   sheet origin of frame 0 (shadow copy)
//               visible_i           object enable (shadow copy)
//               hit_o               pixel covered by this object
//               col_o, row_o        sheet column / row, ADDR_W bits
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_hit
  import sprite_engine_pkg::*;
#(
  parameter int OBJ_W  = C_DEF_OBJ_W,
  parameter int OBJ_H  = C_DEF_OBJ_H,
  parameter int ADDR_W = C_DEF_ADDR_W
) (
  input  logic [C_PIVOT_W-1:0] h_i,
  input  logic [C_PIVOT_W-1:0] v_i,
  input  logic [C_PIVOT_W-1:0] pivot_h_i,
  input  logic [C_PIVOT_W-1:0] pivot_v_i,
  input  logic [C_PIVOT_W-1:0] base_h_i,
  input  logic [C_PIVOT_W-1:0] base_v_i,
  input  logic                 visible_i,
  output logic                 hit_o,
  output logic [ADDR_W-1:0]    col_o,
  output logic [ADDR_W-1:0]    row_o
);

  // One extra bit so a pixel left of / above the pivot shows up as negative.
  logic [C_PIVOT_W:0] w_dx;
  logic [C_PIVOT_W:0] w_dy;
  logic               w_in_h;
  logic               w_in_v;

  assign w_dx = {1'b0, h_i} - {1'b0, pivot_h_i};
  assign w_dy = {1'b0, v_i} - {1'b0, pivot_v_i};

  assign w_in_h = !w_dx[C_PIVOT_W] && (w_dx < (C_PIVOT_W+1)'(OBJ_W));
  assign w_in_v = !w_dy[C_PIVOT_W] && (w_dy < (C_PIVOT_W+1)'(OBJ_H));

  assign hit_o = visible_i && w_in_h && w_in_v;

  // Only meaningful on a hit, where dx/dy are known non-negative.
  assign col_o = ADDR_W'(base_h_i) + ADDR_W'(w_dx[C_PIVOT_W-1:0]);
  assign row_o = ADDR_W'(base_v_i) + ADDR_W'(w_dy[C_PIVOT_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/sprite_engine.sv
`default_nettype none
// ============================================================================
// Module      : sprite_engine
// Description : Multi-object sprite engine. Converts the current VGA pixel to
//               logical coordinates, hit-tests every object against shadowed
//               object state, selects the lowest-index hit and produces the
//               sprite-sheet address two cycles later, one pixel per cycle.
// Ports       : clk    pixel clock
//               rst_n  asynchronous active-low reset
//               bus    sprite_engine_if.slave (pixel in, object table,
//                      animation enable, addr/en/obj_id out)
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_engine
  import sprite_engine_pkg::*;
#(
  parameter int NUM_OBJ     = C_DEF_NUM_OBJ,
  parameter int OBJ_W       = C_DEF_OBJ_W,
  parameter int OBJ_H       = C_DEF_OBJ_H,
  parameter int MEM_W       = C_DEF_MEM_W,
  parameter int ADDR_W      = C_DEF_ADDR_W,
  parameter int SCALE_SHIFT = C_DEF_SCALE_SHIFT,
  parameter int NUM_FRAMES  = C_DEF_NUM_FRAMES,
  parameter int FRAME_DIV   = C_DEF_FRAME_DIV
) (
  input  logic           clk,
  input  logic           rst_n,
  sprite_engine_if.slave bus
);

  localparam int ID_W = f_idx_w(NUM_OBJ);
  localparam int FC_W = f_idx_w(FRAME_DIV);
  localparam int AI_W = f_idx_w(NUM_FRAMES);
  localparam int TW   = C_PIVOT_W * NUM_OBJ;

  // --------------------------------------------------------------------------
  // Shadow object table, reloaded only on frame_start
  // --------------------------------------------------------------------------
  logic [TW-1:0]      pivot_h_q, pivot_v_q, base_h_q, base_v_q;
  logic [NUM_OBJ-1:0] visible_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pivot_h_q <= '0;
      pivot_v_q <= '0;
      base_h_q  <= '0;
      base_v_q  <= '0;
      visible_q <= '0;
    end else if (bus.frame_start_i) begin
      pivot_h_q <= bus.pivot_h_i;
      pivot_v_q <= bus.pivot_v_i;
      base_h_q  <= bus.mem_base_h_i;
      base_v_q  <= bus.mem_base_v_i;
      visible_q <= bus.obj_visible_i;
    end
  end

  // --------------------------------------------------------------------------
  // Animation counters
  // --------------------------------------------------------------------------
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [AI_W-1:0] anim_idx_q, anim_idx_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    anim_idx_d  = anim_idx_q;
    if (bus.frame_start_i && bus.anim_en_i) begin
      if (frame_cnt_q == FC_W'(FRAME_DIV - 1)) begin
        frame_cnt_d = '0;
        if (anim_idx_q == AI_W'(NUM_FRAMES - 1)) anim_idx_d = '0;
        else                                     anim_idx_d = anim_idx_q + 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      anim_idx_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      anim_idx_q  <= anim_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: per-object hit test
  // --------------------------------------------------------------------------
  logic [C_PIVOT_W-1:0] w_h, w_v;
  logic [NUM_OBJ-1:0]   w_hit;
  logic [ADDR_W-1:0]    w_col [NUM_OBJ];
  logic [ADDR_W-1:0]    w_row [NUM_OBJ];

  assign w_h = bus.vga_h_i >> SCALE_SHIFT;
  assign w_v = bus.vga_v_i >> SCALE_SHIFT;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    sprite_hit #(
      .OBJ_W  (OBJ_W),
      .OBJ_H  (OBJ_H),
      .ADDR_W (ADDR_W)
    ) u_hit (
      .h_i       (w_h),
      .v_i       (w_v),
      .pivot_h_i (pivot_h_q[C_PIVOT_W*g +: C_PIVOT_W]),
      .pivot_v_i (pivot_v_q[C_PIVOT_W*g +: C_PIVOT_W]),
      .base_h_i  (base_h_q[C_PIVOT_W*g +: C_PIVOT_W]),
      .base_v_i  (base_v_q[C_PIVOT_W*g +: C_PIVOT_W]),
      .visible_i (visible_q[g]),
      .hit_o     (w_hit[g]),
      .col_o     (w_col[g]),
      .row_o     (w_row[g])
    );
  end

  // Sheet bases and the animation offset are folded in at stage 1 so that a
  // pixel sampled on a frame_start edge sees only pre-update state, even
  // though the shadows and anim_idx change before stage 2 runs.
  logic [NUM_OBJ-1:0] hit_q;
  logic [ADDR_W-1:0]  col_q [NUM_OBJ];
  logic [ADDR_W-1:0]  row_q [NUM_OBJ];
  logic [ADDR_W-1:0]  anim_off_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q      <= '0;
      anim_off_q <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        col_q[i] <= '0;
        row_q[i] <= '0;
      end
    end else begin
      hit_q      <= w_hit;
      anim_off_q <= ADDR_W'(anim_idx_q) * ADDR_W'(OBJ_W);
      for (int i = 0; i < NUM_OBJ; i++) begin
        col_q[i] <= w_col[i];
        row_q[i] <= w_row[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: priority select (lowest index wins) and address
  // --------------------------------------------------------------------------
  logic              en_d, en_q;
  logic [ID_W-1:0]   obj_id_d, obj_id_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W-1:0] w_win_col, w_win_row;

  always_comb begin
    en_d      = 1'b0;
    obj_id_d  = '0;
    w_win_col = '0;
    w_win_row = '0;
    // Scan high to low so the last assignment is the lowest hitting index.
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        en_d      = 1'b1;
        obj_id_d  = ID_W'(i);
        w_win_col = col_q[i];
        w_win_row = row_q[i];
      end
    end
    addr_d = en_d ? (w_win_col + anim_off_q + ADDR_W'(MEM_W) * w_win_row) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      obj_id_q <= '0;
      addr_q   <= '0;
    end else begin
      en_q     <= en_d;
      obj_id_q <= obj_id_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.en_o     = en_q;
  assign bus.obj_id_o = obj_id_q;
  assign bus.addr_o   = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_engine
// Description : Directed self-checking bench for sprite_engine with two
//               objects, 21x26 boxes, 320-pixel sheet pitch, FRAME_DIV=2 and
//               NUM_FRAMES=3.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_engine;

  localparam int NUM_OBJ = 2;
  localparam int ADDR_W  = 17;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sprite_engine_if #(.NUM_OBJ(NUM_OBJ), .ADDR_W(ADDR_W)) bus ();

  sprite_engine #(
    .NUM_OBJ     (NUM_OBJ),
    .OBJ_W       (21),
    .OBJ_H       (26),
    .MEM_W       (320),
    .ADDR_W      (ADDR_W),
    .SCALE_SHIFT (1),
    .NUM_FRAMES  (3),
    .FRAME_DIV   (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int en, input int addr, input int id);
    chk({tag, ".en"},     32'(bus.en_o),     32'(en));
    chk({tag, ".addr"},   32'(bus.addr_o),   32'(addr));
    chk({tag, ".obj_id"}, 32'(bus.obj_id_o), 32'(id));
  endtask

  task automatic set_obj(input int i, input int ph, input int pv,
                         input int bh, input int bv, input logic vis);
    bus.pivot_h_i[10*i +: 10]    = 10'(ph);
    bus.pivot_v_i[10*i +: 10]    = 10'(pv);
    bus.mem_base_h_i[10*i +: 10] = 10'(bh);
    bus.mem_base_v_i[10*i +: 10] = 10'(bv);
    bus.obj_visible_i[i]         = vis;
  endtask

  // One clock edge with frame_start high.
  task automatic pulse();
    @(negedge clk);
    bus.frame_start_i = 1'b1;
    @(negedge clk);
    bus.frame_start_i = 1'b0;
  endtask

  // Apply a pixel and return on the negedge after its result is registered.
  task automatic query(input int h, input int v);
    @(negedge clk);
    bus.vga_h_i = 10'(h);
    bus.vga_v_i = 10'(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.vga_h_i = '0;  bus.vga_v_i = '0;
    bus.frame_start_i = 1'b0;  bus.anim_en_i = 1'b0;
    bus.pivot_h_i = '0;  bus.pivot_v_i = '0;
    bus.mem_base_h_i = '0;  bus.mem_base_v_i = '0;
    bus.obj_visible_i = '0;

    #12;
    chk_out("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Object programmed but shadows not yet loaded.
    set_obj(0, 10, 20, 0, 1, 1'b1);
    set_obj(1, 10, 20, 100, 0, 1'b0);
    query(20, 40);
    chk("no_load.en", 32'(bus.en_o), 0);

    pulse();
    query(20, 40);  chk_out("basic", 1, 320, 0);
    query(61, 40);  chk_out("right_edge", 1, 340, 0);
    query(62, 40);  chk_out("past_right", 0, 0, 0);
    query(18, 40);  chk_out("left_of_pivot", 0, 0, 0);
    query(20, 91);  chk_out("bottom_edge", 1, 8320, 0);
    query(20, 92);  chk_out("past_bottom", 0, 0, 0);

    // Asynchronous reset mid-stream.
    query(20, 40);
    chk("pre_rst.en", 32'(bus.en_o), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    query(20, 40);  chk("post_rst.en", 32'(bus.en_o), 0);
    pulse();
    query(20, 40);  chk_out("post_rst_load", 1, 320, 0);

    // Priority between two overlapping objects.
    set_obj(1, 10, 20, 100, 0, 1'b1);
    pulse();
    query(20, 40);  chk_out("prio_both", 1, 320, 0);
    bus.obj_visible_i[0] = 1'b0;
    pulse();
    query(20, 40);  chk_out("prio_obj1", 1, 100, 1);

    // Shadowing: pivot changes take effect only at frame_start.
    set_obj(0, 10, 20, 0, 1, 1'b1);
    set_obj(1, 10, 20, 100, 0, 1'b0);
    pulse();
    set_obj(0, 50, 50, 0, 1, 1'b1);
    query(20, 40);  chk_out("no_pulse", 1, 320, 0);
    // Pixel sampled on the same edge as the reload uses old shadows.
    @(negedge clk);
    bus.frame_start_i = 1'b1;
    @(negedge clk);
    bus.frame_start_i = 1'b0;
    @(negedge clk);
    chk("same_edge.en", 32'(bus.en_o), 1);
    query(20, 40);  chk_out("after_pulse", 0, 0, 0);

    // Animation: FRAME_DIV=2, NUM_FRAMES=3.
    set_obj(0, 10, 20, 0, 1, 1'b1);
    pulse();
    bus.anim_en_i = 1'b1;
    repeat (2) pulse();
    query(20, 40);  chk_out("anim_2", 1, 341, 0);
    repeat (2) pulse();
    query(20, 40);  chk_out("anim_4", 1, 362, 0);
    repeat (2) pulse();
    query(20, 40);  chk_out("anim_6", 1, 320, 0);
    repeat (2) pulse();
    query(20, 40);  chk("anim_8.addr", 32'(bus.addr_o), 341);
    bus.anim_en_i = 1'b0;
    repeat (2) pulse();
    query(20, 40);  chk("anim_hold.addr", 32'(bus.addr_o), 341);
    bus.anim_en_i = 1'b1;
    pulse();
    query(20, 40);  chk("anim_resume1.addr", 32'(bus.addr_o), 341);
    pulse();
    query(20, 40);  chk("anim_resume2.addr", 32'(bus.addr_o), 362);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 Parameter NUM_OBJ, default 4, number of sprite objects; object 0 has highest priority.
REQ-002 Parameter OBJ_W, default 21, object width in logical pixels.
REQ-003 Parameter OBJ_H, default 26, object height in logical pixels.
REQ-004 Parameter MEM_W, default 320, sprite-sheet row pitch in pixels.
REQ-005 Parameter ADDR_W, default 17, sprite-memory address width.
REQ-006 Parameter SCALE_SHIFT, default 1, VGA-to-logical right shift.
REQ-007 Parameter NUM_FRAMES, default 4, animation frames per object.
REQ-008 Parameter FRAME_DIV, default 8, VGA frames per animation step.
REQ-009 clk  in  1  pixel clock.
REQ-010 rst_n  in  1  reset, asynchronous and active-low.
REQ-011 vga_h, vga_v  in  10 each  current VGA pixel coordinates.
REQ-012 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-013 pivot_h, pivot_v  in  10*NUM_OBJ each  packed per-object logical top-left corner; object i is at bits [10i+9:10i].
REQ-014 mem_base_h, mem_base_v  in  10*NUM_OBJ each  packed per-object sheet origin of animation frame 0.
REQ-015 obj_visible  in  NUM_OBJ  per-object enable.
REQ-016 anim_en  in  1  animation advance enable.
REQ-017 addr  out  ADDR_W  sprite-memory address.
REQ-018 en  out  1  the current pixel is covered by a visible object.
REQ-019 obj_id  out  clog2(NUM_OBJ)  index of the winning object.

Function
REQ-020 Logical coordinates SHALL be h = vga_h>>SCALE_SHIFT and v = vga_v>>SCALE_SHIFT.
REQ-021 Object i SHALL hit only when all hold:
- its shadow obj_visible is 1;
- 0 <= h-pivot_h < OBJ_W and 0 <= v-pivot_v < OBJ_H, evaluated as 11-bit signed differences so that h < pivot_h never hits.
REQ-022 When several objects hit, the lowest index SHALL win.
REQ-023 pivot_h, pivot_v, mem_base_h, mem_base_v and obj_visible SHALL be captured into shadow registers only on a clock edge where frame_start=1; the hit test uses only the shadow copies.
REQ-024 A pixel sampled on the same edge as frame_start SHALL use the pre-update shadow values.
REQ-025 Address SHALL be addr = (base_h + anim_idx*OBJ_W + dx) + MEM_W*(base_v + dy), truncated to ADDR_W bits, where:
- dx = h-pivot_h and dy = v-pivot_v;
- base_h and base_v are the winner's shadow sheet origin.
REQ-026 When no object hits, the block SHALL drive en=0, addr=0 and obj_id=0.
REQ-027 Latency SHALL be exactly 2 cycles, fully pipelined with one pixel per cycle:
- stage 1 registers h, v and the per-object hit and offset values;
- stage 2 registers the priority select and the address.
REQ-028 Animation counters SHALL advance on each frame_start pulse while anim_en=1:
- frame_cnt counts 0..FRAME_DIV-1 and wraps to 0;
- on that wrap, anim_idx counts 0..NUM_FRAMES-1 and wraps to 0.
REQ-029 While anim_en=0, frame_cnt and anim_idx SHALL hold their values.
REQ-030 The anim_idx value used in the address SHALL be the value held before the current edge, consistent with REQ-024.

Reset
REQ-031 While rst_n=0, all of the following SHALL be cleared to 0 immediately, without waiting for clk:
- all outputs;
- pipeline registers;
- shadow registers, so all objects are invisible;
- frame_cnt and anim_idx.
REQ-032 Asserting rst_n mid-frame SHALL flush the pipeline; en SHALL stay 0 until shadows are loaded by a frame_start pulse after reset release.

Structure
REQ-033 A shared package/header SHALL hold the default parameter constants and the pivot field width (10).
REQ-034 One sub-module, sprite_hit, SHALL perform the per-object hit test and offset computation and SHALL be instantiated NUM_OBJ times by generate.

Verification
All scenarios use NUM_OBJ=2, OBJ_W=21, OBJ_H=26, MEM_W=320, SCALE_SHIFT=1 and obj0 base (0,1), unless stated otherwise.
REQ-035 Reset with rst_n=0 mid-stream -> en=0, addr=0, obj_id=0 immediately, and en remains 0 after release until a frame_start pulse.
REQ-036 obj0 pivot (10,20), frame_start pulse, then vga=(20,40) -> 2 cycles later en=1, obj_id=0, addr=320.
REQ-037 Edge of obj0 from REQ-036:
- vga_h=61 -> addr=340;
- vga_h=62 -> en=0;
- vga_h=18 (h=9 < pivot) -> en=0.
REQ-038 obj1 pivot (10,20), base (100,0), both objects visible, vga=(20,40) -> obj_id=0, addr=320.
REQ-039 Repeat REQ-038 with obj0 invisible -> obj_id=1, addr=100.
REQ-040 Change obj0 pivot to (50,50) without frame_start -> vga=(20,40) still en=1; after a frame_start pulse the same pixel gives en=0.
REQ-041 FRAME_DIV=2, NUM_FRAMES=3, anim_en=1:
- after 2 frame_start pulses, the REQ-036 pixel gives addr=341;
- after 6 pulses, it gives addr=320;
- with anim_en=0, the address is unchanged across pulses.
